uart_rx_os: RTL

- UART receiver with 16x oversampling. It deframes 8N1 serial data on `uart_rx` into bytes for the CPU-side peripheral bus.
- It generates its sample tick internally as a single-cycle enable on `sysclk`, using the same divider ratio as the existing baud/sample generator: 100 MHz / 650 ≈ 16 × 9615 baud. No derived clocks.
- Holds one received byte until the consumer acknowledges it, and flags overrun and framing errors.

---
 rtl/uart_rx_os.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// One system clock. The sample tick is a one-cycle enable made from a divider on
// sysclk. The received byte is held in rx_data until rx_ack. Overrun and
// framing errors are sticky flags that rx_ack clears.
module uart_rx_os #(
    parameter int SAM_DIV = 650,   // sysclk cycles per sample tick
    parameter int OS      = 16     // samples per bit (4-bit sample counter)
) (
    input  logic       sysclk,
    input  logic       reset,      // asynchronous, active low
    input  logic       uart_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int TW = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(SAM_DIV - 1);
    localparam logic [3:0]    SAMPLE_LAST = 4'(OS - 1);
    localparam logic [3:0]    MID_LO      = 4'(OS / 2 - 1);
    localparam logic [3:0]    MID         = 4'(OS / 2);
    localparam logic [3:0]    MID_HI      = 4'(OS / 2 + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_reg, state_next;

    logic           rx_meta_reg;
    logic           rxs;
    logic [TW-1:0]  tick_cnt_reg;
    logic           tick;
    logic [3:0]     samp_cnt_reg;
    logic [2:0]     bit_cnt_reg;
    logic [2:0]     win_reg;
    logic [7:0]     shift_reg;
    logic           vote;
    logic           end_of_bit;
    logic           mid_sample;

    // Strobes produced by the FSM decode.
    logic           start_det;
    logic           shift_en;
    logic           load_byte;
    logic           set_ferr;

    assign tick       = (tick_cnt_reg == TICK_LAST);
    assign end_of_bit = tick && (samp_cnt_reg == SAMPLE_LAST);
    assign mid_sample = (samp_cnt_reg == MID_LO) || (samp_cnt_reg == MID) ||
                        (samp_cnt_reg == MID_HI);
    assign vote       = (win_reg[0] & win_reg[1]) | (win_reg[0] & win_reg[2]) |
                        (win_reg[1] & win_reg[2]);
    assign rx_busy    = (state_reg != IDLE);

    // Two-flop synchronizer; both flops reset to the idle (high) line level.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rxs         <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rxs         <= rx_meta_reg;
        end
    end

    // Sample-tick divider; restarts on the start edge so ticks line up with the bit cells.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tick_cnt_reg <= '0;
        end else if (start_det || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // Sample and bit counters; the sample counter wraps 15->0 once per bit cell.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            samp_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (start_det) begin
            samp_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            if (tick) begin
                samp_cnt_reg <= samp_cnt_reg + 1'b1;
            end
            if (shift_en) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // Vote window gathers the three mid-cell samples; data bits enter LSB first.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            win_reg   <= '0;
            shift_reg <= '0;
        end else begin
            if (tick && mid_sample) begin
                win_reg <= {win_reg[1:0], rxs};
            end
            if (shift_en) begin
                shift_reg <= {vote, shift_reg[7:1]};
            end
        end
    end

    // FSM state register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and datapath strobes.
    always_comb begin
        state_next = state_reg;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        load_byte  = 1'b0;
        set_ferr   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    start_det  = 1'b1;
                end
            end
            START: begin
                // A high vote means the falling edge was a glitch, not a start bit.
                if (end_of_bit) begin
                    state_next = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (end_of_bit) begin
                    shift_en = 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (end_of_bit) begin
                    state_next = IDLE;
                    if (vote) begin
                        load_byte = 1'b1;
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Consumer-facing registers: a completed byte takes priority over a same-cycle ack.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data   <= '0;
            rx_status <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid <= load_byte;
            if (load_byte) begin
                rx_data   <= shift_reg;
                rx_status <= 1'b1;
                overrun   <= rx_ack ? 1'b0 : (overrun | rx_status);
                frame_err <= rx_ack ? 1'b0 : frame_err;
            end else if (set_ferr) begin
                frame_err <= 1'b1;
                if (rx_ack) begin
                    rx_status <= 1'b0;
                    overrun   <= 1'b0;
                end
            end else if (rx_ack) begin
                rx_status <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
        end
    end

endmodule
